// File: rtl/hwpe_stream_package.sv
// Shared types for the hwpe_stream copy-network fault supervision logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hwpe_stream_package;

    // Supervisor phases: idle, settle after enable, watch sinks, sticky fault.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        MONITOR = 2'd2,
        FAULT   = 2'd3
    } copy_fault_state_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros (index of lowest set bit).
// Latency: combinational.
// Backpressure: none.
// Ports: in_i vector to scan, cnt_o zero count, empty_o high when in_i has no set bit.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (!MODE) begin
            // Scan downwards so the lowest set bit is the last one written.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end
            end
        end else begin
            // Scan upwards so the highest set bit is the last one written.
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
                end
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_copy_fault_ctrl.sv
// Supervises copy-sink mismatch flags: settle after enable, then latch a sticky fault, count and interrupt.
// Latency: 1 cycle from a sampled unmasked hit to fault_o/irq_o; all outputs registered.
// Backpressure: none; flags are sampled every cycle and never stalled.
// Ports: clk_i/rst_i (async active-high), enable_i level, clear_i pulse, sink_mask_i (1 = ignore),
//        fault_i raw sink flags; armed_o, fault_o, irq_o, fault_mask_o, first_idx_o, fault_cnt_o status.
module hwpe_stream_copy_fault_ctrl
    import hwpe_stream_package::*;
#(
    parameter  int unsigned NB_SINKS   = 4,
    parameter  int unsigned ARM_CYCLES = 4,
    parameter  int unsigned CNT_WIDTH  = 8,
    localparam int unsigned IDX_W      = (NB_SINKS > 1) ? $clog2(NB_SINKS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [NB_SINKS-1:0]  sink_mask_i,
    input  logic [NB_SINKS-1:0]  fault_i,
    output logic                 armed_o,
    output logic                 fault_o,
    output logic                 irq_o,
    output logic [NB_SINKS-1:0]  fault_mask_o,
    output logic [IDX_W-1:0]     first_idx_o,
    output logic [CNT_WIDTH-1:0] fault_cnt_o
);

    localparam int unsigned  AW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);

    copy_fault_state_t     state_q, state_d;
    logic [AW-1:0]         arm_cnt_q, arm_cnt_d;
    logic [NB_SINKS-1:0]   fault_mask_q, fault_mask_d;
    logic [IDX_W-1:0]      first_idx_q, first_idx_d;
    logic                  irq_q, irq_d;
    logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;

    logic [NB_SINKS-1:0]   hit_vec;
    logic [IDX_W-1:0]      lowest_idx;
    logic                  hit_none;
    logic                  hit;
    logic                  watching;

    assign hit_vec = fault_i & ~sink_mask_i;
    // The encoder's empty flag doubles as the "no unmasked hit" indication.
    assign hit     = ~hit_none;

    lzc #(
        .WIDTH     (NB_SINKS),
        .MODE      (1'b0),
        .CNT_WIDTH (IDX_W)
    ) i_first_idx_lzc (
        .in_i    (hit_vec),
        .cnt_o   (lowest_idx),
        .empty_o (hit_none)
    );

    assign watching = (state_q == MONITOR) || (state_q == FAULT);

    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        fault_mask_d = fault_mask_q;
        first_idx_d  = first_idx_q;
        irq_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d   = ARMING;
                    arm_cnt_d = ARM_LOAD;
                end
            end
            ARMING: begin
                // Flags are still settling here, so hits are deliberately ignored.
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (arm_cnt_q == '0) begin
                    state_d = MONITOR;
                end else begin
                    arm_cnt_d = arm_cnt_q - 1'b1;
                end
            end
            MONITOR: begin
                // A hit outranks a same-cycle disable so no fault is lost.
                if (hit) begin
                    state_d      = FAULT;
                    first_idx_d  = lowest_idx;
                    fault_mask_d = hit_vec;
                    irq_d        = 1'b1;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (clear_i) begin
                    fault_mask_d = '0;
                    first_idx_d  = '0;
                    if (enable_i) begin
                        state_d   = ARMING;
                        arm_cnt_d = ARM_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    fault_mask_d = fault_mask_q | hit_vec;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear beats a same-cycle increment; the counter sticks at all-ones.
        if (clear_i) begin
            fault_cnt_d = '0;
        end else if (watching && hit && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end else begin
            fault_cnt_d = fault_cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            arm_cnt_q    <= '0;
            fault_mask_q <= '0;
            first_idx_q  <= '0;
            irq_q        <= 1'b0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            fault_mask_q <= fault_mask_d;
            first_idx_q  <= first_idx_d;
            irq_q        <= irq_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign armed_o      = (state_q == MONITOR);
    assign fault_o      = (state_q == FAULT);
    assign irq_o        = irq_q;
    assign fault_mask_o = fault_mask_q;
    assign first_idx_o  = first_idx_q;
    assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_copy_fault_ctrl.sv
// Bench for hwpe_stream_copy_fault_ctrl: directed scenarios then random traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hwpe_stream_copy_fault_ctrl;

    localparam int ARM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr;
    logic [3:0] smask, flt;

    logic       armed, fault, irq;
    logic [3:0] fmask;
    logic [1:0] fidx;
    logic [7:0] cnt;

    logic       s_armed, s_fault, s_irq;
    logic [3:0] s_fmask;
    logic [1:0] s_fidx;
    logic [1:0] s_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase flags, settle age, and raw number of hit cycles since last clear.
    bit         m_active, m_armed, m_faulted, m_irq;
    int         m_age;
    logic [3:0] m_mask;
    int         m_idx;
    int         m_hits;

    always #5 clk = ~clk;

    hwpe_stream_copy_fault_ctrl #(.NB_SINKS(4), .ARM_CYCLES(ARM), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .sink_mask_i(smask), .fault_i(flt),
        .armed_o(armed), .fault_o(fault), .irq_o(irq),
        .fault_mask_o(fmask), .first_idx_o(fidx), .fault_cnt_o(cnt)
    );

    hwpe_stream_copy_fault_ctrl #(.NB_SINKS(4), .ARM_CYCLES(ARM), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .sink_mask_i(smask), .fault_i(flt),
        .armed_o(s_armed), .fault_o(s_fault), .irq_o(s_irq),
        .fault_mask_o(s_fmask), .first_idx_o(s_fidx), .fault_cnt_o(s_cnt)
    );

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_armed = 0; m_faulted = 0; m_irq = 0;
        m_age = 0; m_mask = '0; m_idx = 0; m_hits = 0;
    endtask

    task automatic model_edge();
        logic [3:0] hv;
        bit hit, was_mon, was_flt;
        hv = flt & ~smask;
        hit = |hv;
        was_mon = m_armed;
        was_flt = m_faulted;
        m_irq = 0;
        if (was_flt) begin
            if (clr) begin
                m_faulted = 0; m_mask = '0; m_idx = 0;
                m_active = en; m_age = 0;
            end else begin
                m_mask = m_mask | hv;
            end
        end else if (was_mon) begin
            if (hit) begin
                m_armed = 0; m_active = 0; m_faulted = 1;
                m_mask = hv; m_idx = lowest(hv); m_irq = 1;
            end else if (!en) begin
                m_armed = 0; m_active = 0;
            end
        end else if (m_active) begin
            if (!en) m_active = 0;
            else begin
                m_age++;
                if (m_age >= ARM) m_armed = 1;
            end
        end else if (en) begin
            m_active = 1; m_age = 0;
        end
        if (clr) m_hits = 0;
        else if ((was_mon || was_flt) && hit) m_hits++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_armed"}, armed, m_armed);
        chk({tag, "_fault"}, fault, m_faulted);
        chk({tag, "_irq"}, irq, m_irq);
        chk({tag, "_mask"}, fmask, m_mask);
        chk({tag, "_idx"}, fidx, m_idx);
        chk({tag, "_cnt"}, cnt, sat(m_hits, 255));
        chk({tag, "_s_armed"}, s_armed, m_armed);
        chk({tag, "_s_fault"}, s_fault, m_faulted);
        chk({tag, "_s_irq"}, s_irq, m_irq);
        chk({tag, "_s_cnt"}, s_cnt, sat(m_hits, 3));
    endtask

    task automatic step(input string tag, input logic e, input logic c,
                        input logic [3:0] m, input logic [3:0] f);
        en = e; clr = c; smask = m; flt = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; en = 0; clr = 0; smask = '0; flt = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Arming: sink flags all high through the settle window, including its last cycle.
        for (int i = 0; i < ARM; i++) begin
            step("arming", 1, 0, 4'b0000, 4'b1111);
            chk("arming_not_yet", armed, 0);
        end
        step("arming_last", 1, 0, 4'b0000, 4'b1111);
        chk("arm_rise", armed, 1);
        chk("arm_cnt_zero", cnt, 0);

        // Detection in the first monitor cycle.
        step("detect", 1, 0, 4'b0000, 4'b0110);
        chk("det_irq", irq, 1);
        chk("det_idx", fidx, 1);
        chk("det_mask", fmask, 4'b0110);
        chk("det_cnt", cnt, 1);
        step("detect_after", 1, 0, 4'b0000, 4'b0000);
        chk("det_irq_drop", irq, 0);

        // Accumulation, then clear with enable held.
        step("accum", 1, 0, 4'b0000, 4'b1000);
        chk("acc_mask", fmask, 4'b1110);
        step("clear", 1, 1, 4'b0000, 4'b0000);
        chk("clr_mask", fmask, 0);
        chk("clr_cnt", cnt, 0);
        for (int i = 0; i < ARM - 1; i++) step("rearm", 1, 0, 4'b0000, 4'b0000);
        chk("rearm_not_yet", armed, 0);
        step("rearm_last", 1, 0, 4'b0000, 4'b0000);
        chk("rearm_rise", armed, 1);

        // Masked sink is invisible; then saturation of the narrow counter.
        for (int i = 0; i < 10; i++) step("masked", 1, 0, 4'b0001, 4'b0001);
        chk("masked_fault", fault, 0);
        chk("masked_cnt", cnt, 0);
        for (int i = 0; i < 10; i++) step("satur", 1, 0, 4'b0001, 4'b0011);
        chk("sat_idx", fidx, 1);
        chk("sat_cnt2", s_cnt, 3);
        chk("sat_cnt8", cnt, 10);

        // Disable and hit in the same monitor cycle: the fault wins.
        step("sim_clr", 1, 1, 4'b0000, 4'b0000);
        for (int i = 0; i < ARM; i++) step("sim_arm", 1, 0, 4'b0000, 4'b0000);
        step("sim_hit", 0, 0, 4'b0000, 4'b0001);
        chk("sim_fault", fault, 1);
        step("sim_clr_idle", 0, 1, 4'b0000, 4'b0000);
        chk("sim_idle_fault", fault, 0);
        step("sim_idle", 0, 0, 4'b0000, 4'b1111);

        // Reset in the middle of a fault with five counted hit cycles.
        step("rm_en", 1, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < ARM; i++) step("rm_arm", 1, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) step("rm_hit", 1, 0, 4'b0000, 4'b0001);
        chk("rm_cnt5", cnt, 5);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rm_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("rm_idle", 0, 0, 4'b0000, 4'b1111);
        for (int i = 0; i <= ARM; i++) step("rm_rearm", 1, 0, 4'b0000, 4'b0000);
        chk("rm_rearm_rise", armed, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom % 8) != 0,
                 ($urandom % 12) == 0,
                 4'($urandom),
                 (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
